// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encodings and the default HALT opcode.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter register: jump load has priority over increment, otherwise holds.
module pc_counter #(
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc;

    // PC update; increment wraps naturally modulo 2**ADDR_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VAL;
        end else if (load) begin
            r_pc <= load_val;
        end else if (inc) begin
            r_pc <= r_pc + ONE;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives ROM address from the PC and registers the ROM word behind a valid/ready handshake.
// Optional self-halt on HALT_OP is enabled by defining FETCH_HALT_DETECT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int         ADDR_W   = 4,
    parameter int         DATA_W   = 16,
    parameter int         RESET_PC = 0,
    parameter logic [3:0] HALT_OP  = HALT_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

`ifdef FETCH_HALT_DETECT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    fetch_state_e      r_state;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_halted;

    logic [ADDR_W-1:0] w_pc;
    logic              w_load;
    logic              w_halt_hit;

    assign w_load     = (r_state == ST_RUN) && en && !jump_valid && (!r_instr_valid || instr_ready);
    assign w_halt_hit = HALT_EN && (rom_data[DATA_W-1 -: 4] == HALT_OP);

    // A captured HALT word leaves the PC pointing at itself
    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (jump_valid),
        .load_val (jump_addr),
        .inc      (w_load && !w_halt_hit),
        .pc       (w_pc)
    );

    assign rom_addr = w_pc;

    // Control FSM and output register; a jump flushes the held word and overrides everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_instr       <= {DATA_W{1'b0}};
            r_instr_pc    <= {ADDR_W{1'b0}};
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else if (jump_valid) begin
            r_state       <= en ? ST_RUN : ST_IDLE;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            if (w_load) begin
                r_instr       <= rom_data;
                r_instr_pc    <= w_pc;
                r_instr_valid <= 1'b1;
            end else if (instr_ready) begin
                r_instr_valid <= 1'b0;
            end else begin
                r_instr_valid <= r_instr_valid;
            end

            case (r_state)
                ST_IDLE: begin
                    r_state <= en ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                    end else if (w_load && w_halt_hit) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic checked against a transaction-level model.
// Build with FETCH_HALT_DETECT_EN defined to exercise the self-halt expectations.
module tb_instr_fetch;

    localparam int AW = 4;
    localparam int DW = 16;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          jump_valid;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          halted;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a fetch cursor, a one-entry holding slot, and a run/idle/halt mode
    int            m_mode;   // 0 idle, 1 running, 2 halted
    int            m_pc;
    bit            m_valid;
    logic [DW-1:0] m_instr;
    int            m_ipc;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 4'd5) return 16'hF0AA;
        return 16'h1000 + {12'd0, a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_valid = 1'b0; m_instr = '0; m_ipc = 0;
    endtask

    // One clock of the fetch rules, evaluated on the inputs present at the edge
    task automatic model_step();
        int old_mode;
        logic [DW-1:0] w;
        old_mode = m_mode;
        if (jump_valid) begin
            m_pc    = int'(jump_addr);
            m_valid = 1'b0;
            m_mode  = en ? 1 : 0;
        end else begin
            if (old_mode == 1 && en && (!m_valid || instr_ready)) begin
                w       = rom_word(AW'(m_pc));
                m_instr = w;
                m_ipc   = m_pc;
                m_valid = 1'b1;
                if (HALT_EN && w[15:12] == 4'hF) m_mode = 2;
                else m_pc = (m_pc + 1) % 16;
            end else if (m_valid && instr_ready) begin
                m_valid = 1'b0;
            end
            if (old_mode == 0 && en) m_mode = 1;
            if (old_mode == 1 && !en) m_mode = 0;
        end
    endtask

    task automatic check_model();
        check("rom_addr", 32'(rom_addr), 32'(m_pc));
        check("valid", 32'(instr_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_mode == 2));
        if (m_valid) begin
            check("instr", 32'(instr), 32'(m_instr));
            check("instr_pc", 32'(instr_pc), 32'(m_ipc));
        end
    endtask

    task automatic apply(input bit e, input bit rdy, input bit jv, input int ja);
        en = e; instr_ready = rdy; jump_valid = jv; jump_addr = AW'(ja);
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, 32'(instr), 32'h0);
        check({tag, "_ipc"}, 32'(instr_pc), 32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_pc"}, 32'(rom_addr), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // 1: stream from reset
        apply(1, 1, 0, 0);
        check("t1_idle_valid", 32'(instr_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            apply(1, 1, 0, 0);
            check("t1_instr", 32'(instr), 32'h1000 + 32'(k));
            check("t1_ipc", 32'(instr_pc), 32'(k));
        end

        // 2: backpressure holds word and pc
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 0);
            check("t2_hold_instr", 32'(instr), 32'h1003);
            check("t2_hold_pc", 32'(rom_addr), 32'h4);
        end
        apply(1, 1, 0, 0);
        check("t2_resume", 32'(instr), 32'h1004);

        // 3: jump while holding, then wrap
        apply(1, 0, 1, 12);
        check("t3_flush", 32'(instr_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            apply(1, 1, 0, 0);
            check("t3_instr", 32'(instr), 32'h1000 + 32'((12 + k) % 16));
            check("t3_ipc", 32'(instr_pc), 32'((12 + k) % 16));
        end

        // 4: en=0 freezes pc but the held word is still consumable
        apply(0, 0, 0, 0);
        check("t4_held", 32'(instr), 32'h1000);
        apply(0, 1, 0, 0);
        check("t4_drained", 32'(instr_valid), 32'h0);
        apply(0, 1, 0, 0);
        check("t4_frozen_pc", 32'(rom_addr), 32'h1);
        apply(1, 1, 0, 0);
        apply(1, 1, 0, 0);
        check("t4_resume", 32'(instr), 32'h1001);

        // 5: HALT opcode at address 5
        do_reset();
        apply(1, 1, 0, 0);
        for (int k = 0; k < 6; k++) apply(1, 1, 0, 0);
        check("t5_halt_word", 32'(instr), 32'hF0AA);
        check("t5_halt_ipc", 32'(instr_pc), 32'h5);
        apply(1, 1, 0, 0);
`ifdef FETCH_HALT_DETECT_EN
        check("t5_halted", 32'(halted), 32'h1);
        check("t5_no_load", 32'(instr_valid), 32'h0);
        for (int k = 0; k < 9; k++) apply(1, 1, 0, 0);
        check("t5_pc_parked", 32'(rom_addr), 32'h5);
        apply(1, 1, 1, 0);
        check("t5_unhalt", 32'(halted), 32'h0);
        apply(1, 1, 0, 0);
        check("t5_restart", 32'(instr), 32'h1000);
`else
        check("t5_next", 32'(instr), 32'h1006);
        check("t5_no_halt", 32'(halted), 32'h0);
`endif

        // 6: asynchronous reset mid-cycle while streaming
        apply(1, 1, 1, 2);
        apply(1, 1, 0, 0);
        apply(1, 1, 0, 0);
        @(posedge clk);
        model_step();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 1, 0, 0);
        apply(1, 1, 0, 0);
        check("t6_restart", 32'(instr), 32'h1000);
        apply(1, 1, 0, 0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
